// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, variable-latency imem handshake,
// instruction latch and next-PC selection. Optional trap: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            instr_ready,
    input  logic            branch,
    input  logic            jump,
    input  logic            jumpr,
    input  logic            zero,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            misalign_err,
`endif
    output logic [31:0]     instr_count
);

    localparam int unsigned OPW = 7;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_t;
`endif

    state_t          state_q, state_d;
    logic            latch, accept, trap;
    logic [XLEN-1:0] target, next_pc;
    logic            alu_lsb_unused;

    assign alu_lsb_unused = alu_result[0];
    assign imem_addr      = pc;
    assign opcode         = instr[OPW-1:0];
    assign pc_plus4       = pc + XLEN'(4);

    // Target selection: jalr > jal > taken branch > sequential
    always_comb begin
        target = pc_plus4;
        if (jumpr) begin
            target = {alu_result[XLEN-1:1], 1'b0};
        end else if (jump || (branch && zero)) begin
            target = pc + imm;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign next_pc = target;
    assign trap    = |target[1:0];
`else
    assign next_pc = {target[XLEN-1:2], 2'b00};
    assign trap    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    latch   = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    accept  = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                    state_d = trap ? S_HALT : S_FETCH;
`else
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_HALT:  state_d = S_HALT;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers; request and valid are decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr       <= NOP;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr_count <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            imem_req    <= (state_d == S_FETCH);
            instr_valid <= (state_d == S_HOLD);
            if (latch) begin
                instr <= imem_rdata;
            end
            if (accept) begin
                instr_count <= instr_count + 32'd1;
                if (!trap) begin
                    pc <= next_pc;
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                if (trap) begin
                    misalign_err <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: randomized memory latency, backpressure
// and control inputs checked against a next-PC reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_ready = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        jumpr = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] imm = 32'd0;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] instr_count;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
        .pc(pc), .pc_plus4(pc_plus4), .instr_ready(instr_ready),
        .branch(branch), .jump(jump), .jumpr(jumpr), .zero(zero),
        .imm(imm), .alu_result(alu_result),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_err(misalign_err),
`endif
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] cnt; int gap; } fetch_exp_t;
    typedef struct { logic [31:0] word; logic [31:0] pc; logic [31:0] cnt; } instr_exp_t;

    fetch_exp_t exp_addr[$];
    instr_exp_t exp_instr[$];
    int tests = 0;
    int fails = 0;
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] model_cnt = 32'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference next PC straight from the selection rules
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic br, input logic jp,
                                             input logic jr, input logic zr,
                                             input logic [31:0] im, input logic [31:0] alu);
        logic [31:0] t;
        if (jr)                    t = alu & ~32'd1;
        else if (jp || (br && zr)) t = p + im;
        else                       t = p + 32'd4;
`ifndef FETCH_MISALIGN_TRAP_EN
        t = t & ~32'd3;
`endif
        return t;
    endfunction

    task automatic rand_ctl();
        branch = 1'($urandom); jump = 1'($urandom); jumpr = 1'($urandom); zero = 1'($urandom);
        imm = $urandom; alu_result = $urandom;
    endtask

    // One fetch/hold/accept round trip with memory delay d and hold delay h
    task automatic run_instr(input int d, input int h, input logic br, input logic jp,
                             input logic jr, input logic zr,
                             input logic [31:0] im, input logic [31:0] alu);
        int n;
        logic [31:0] w, t;
        n = 0;
        while (!imem_req && n < 60) begin @(negedge clk); n++; end
        if (!imem_req) begin
            tests++; fails++;
            $display("FAIL req_timeout: got no imem_req expected one within 60 cycles");
            return;
        end
        imem_rvalid = 1'($urandom); imem_rdata = $urandom; instr_ready = 1'($urandom);
        rand_ctl();
        @(negedge clk);
        for (int i = 0; i < d; i++) begin
            imem_rvalid = 1'b0; instr_ready = 1'($urandom); rand_ctl();
            @(negedge clk);
        end
        w = $urandom;
        imem_rvalid = 1'b1; imem_rdata = w; instr_ready = 1'b0;
        exp_instr.push_back('{w, model_pc, model_cnt});
        @(negedge clk);
        for (int i = 0; i < h; i++) begin
            imem_rvalid = 1'($urandom); imem_rdata = $urandom; instr_ready = 1'b0; rand_ctl();
            @(negedge clk);
        end
        imem_rvalid = 1'($urandom);
        branch = br; jump = jp; jumpr = jr; zero = zr; imm = im; alu_result = alu;
        instr_ready = 1'b1;
        t = ref_next(model_pc, br, jp, jr, zr, im, alu);
        model_cnt = model_cnt + 32'd1;
        if (t[1:0] == 2'b00) begin
            model_pc = t;
            exp_addr.push_back('{t, model_cnt, d + h + 3});
        end
        @(negedge clk);
        instr_ready = 1'b0; imem_rvalid = 1'b0;
    endtask

    task automatic run_rand();
        logic [31:0] im, alu;
        im = $urandom; alu = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
        im[1:0] = 2'b00; alu[1] = 1'b0;
`endif
        run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), im, alu);
    endtask

    // Monitor: checks every request and every cycle an instruction is presented
    int cyc = 0;
    int last_req = 0;
    logic prev_v = 1'b0;
    logic have_cur = 1'b0;
    instr_exp_t cur;
    always @(negedge clk) begin
        fetch_exp_t e;
        if (!rst_n) begin
            prev_v = 1'b0; have_cur = 1'b0;
        end else begin
            cyc++;
            if (imem_req) begin
                if (exp_addr.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL extra_req: got imem_req addr %h expected none", imem_addr);
                end else begin
                    e = exp_addr.pop_front();
                    chk("imem_addr", imem_addr, e.addr);
                    chk("count_at_req", instr_count, e.cnt);
                    if (e.gap != 0) chk("req_gap", 32'(cyc - last_req), 32'(e.gap));
                end
                last_req = cyc;
            end
            if (instr_valid && !prev_v) begin
                if (exp_instr.size() == 0) begin
                    tests++; fails++; have_cur = 1'b0;
                    $display("FAIL extra_instr: got instr %h expected none", instr);
                end else begin
                    cur = exp_instr.pop_front(); have_cur = 1'b1;
                end
            end
            if (instr_valid && have_cur) begin
                chk("instr", instr, cur.word);
                chk("opcode", 32'(opcode), 32'(cur.word[6:0]));
                chk("pc", pc, cur.pc);
                chk("pc_plus4", pc_plus4, cur.pc + 32'd4);
                chk("count_hold", instr_count, cur.cnt);
            end
            if (!instr_valid) have_cur = 1'b0;
            prev_v = instr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_count", instr_count, 32'd0);
        exp_addr.push_back('{RESET_PC, 32'd0, 0});
        rst_n = 1'b1;
        @(negedge clk);

        // Sequential zero-wait, then branches, jumps and wrap
        run_instr(0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(0, 0, 1, 0, 0, 1, 32'hFFFF_FFF8, 0);
        run_instr(4, 5, 0, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(1, 1, 1, 0, 0, 0, 32'hFFFF_FFF8, 0);
        run_instr(0, 0, 0, 0, 1, 0, 0, 32'h21);
        run_instr(0, 2, 0, 1, 0, 0, 32'h100, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        run_instr(0, 0, 0, 1, 1, 0, 32'h40, 32'h201);
`else
        run_instr(0, 0, 0, 1, 1, 0, 32'h40, 32'h203);
`endif
        run_instr(0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC);
        run_instr(0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 40; k++) run_rand();

        // Reset asserted while waiting on memory; responses around it are dropped
        while (!imem_req) @(negedge clk);
        imem_rvalid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0; imem_rvalid = 1'b1; imem_rdata = $urandom;
        #1;
        chk("mid_rst_pc", pc, RESET_PC);
        chk("mid_rst_count", instr_count, 32'd0);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        repeat (3) @(negedge clk);
        exp_addr.delete(); exp_instr.delete();
        model_pc = RESET_PC; model_cnt = 32'd0;
        exp_addr.push_back('{RESET_PC, 32'd0, 0});
        rst_n = 1'b1; imem_rdata = $urandom;
        @(negedge clk);
        chk("idle_discard_valid", 32'(instr_valid), 32'd0);

        for (int k = 0; k < 6; k++) run_rand();

        // Misaligned jump target
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_clear", 32'(misalign_err), 32'd0);
        run_instr(1, 1, 0, 1, 0, 0, 32'h6, 0);
        for (int k = 0; k < 8; k++) begin
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            chk("halt_pc", pc, model_pc);
            chk("misalign_err", 32'(misalign_err), 32'd1);
            @(negedge clk);
        end
`else
        run_instr(1, 1, 0, 1, 0, 0, 32'h6, 0);
        run_instr(0, 0, 0, 0, 0, 0, 0, 0);
`endif
        repeat (4) @(negedge clk);
        chk("pending_fetches", 32'(exp_addr.size()), 32'd0);
        chk("pending_instrs", 32'(exp_instr.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
